// File: rtl/frame_downtimer_pkg.sv
// Shared definitions for the frame down-timer: FSM state encoding and default prescale.
// Used by frame_downtimer and downtimer_prescaler.
package frame_downtimer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } downtimerState_t;

  localparam int DOWNTIMER_PRESCALE_DEFAULT = 50000;

endpackage

// File: rtl/frame_downtimer_prescaler.sv
// Free-running prescaler that counts 0..PRESCALE-1 while enabled.
// Asserts tick combinationally on the terminal count.
module downtimer_prescaler
  import frame_downtimer_pkg::*;
#(
  parameter int PRESCALE = DOWNTIMER_PRESCALE_DEFAULT
) (
  input  logic SC_downTIMER_CLOCK_50,
  input  logic SC_downTIMER_RESET_InHigh,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] preReg;

  assign tick = enable && (preReg == LAST);

  // A disabled prescaler keeps its value so a paused count resumes mid-step.
  always_ff @(posedge SC_downTIMER_CLOCK_50) begin
    if (SC_downTIMER_RESET_InHigh || clear) begin
      preReg <= '0;
    end else if (tick) begin
      preReg <= '0;
    end else if (enable) begin
      preReg <= preReg + PW'(1);
    end
  end

endmodule

// File: rtl/frame_downtimer.sv
// Loadable, pausable down-timer stepping once every DOWNTIMER_PRESCALE clocks.
// Build option FRAME_DOWNTIMER_AUTORELOAD_EN: reload the start value on expiry instead of stopping.
module frame_downtimer
  import frame_downtimer_pkg::*;
#(
  parameter int DOWNTIMER_DATAWIDTH = 24,
  parameter int DOWNTIMER_PRESCALE  = DOWNTIMER_PRESCALE_DEFAULT
) (
  input  logic                           SC_downTIMER_CLOCK_50,
  input  logic                           SC_downTIMER_RESET_InHigh,
  input  logic                           SC_downTIMER_load_InLow,
  input  logic [DOWNTIMER_DATAWIDTH-1:0] SC_downTIMER_loadValue_InBUS,
  input  logic                           SC_downTIMER_pause_InLow,
  output logic [DOWNTIMER_DATAWIDTH-1:0] SC_downTIMER_data_OutBUS,
  output logic                           SC_downTIMER_expired_OutHigh,
  output logic                           SC_downTIMER_running_OutHigh
);

  localparam int DW = DOWNTIMER_DATAWIDTH;

  downtimerState_t stateReg, stateNext;
  logic [DW-1:0]   countReg, countNext;
  logic            expiredReg, expiredNext;
  logic            loadStrobe, preEnable, preClear, tick;

`ifdef FRAME_DOWNTIMER_AUTORELOAD_EN
  logic [DW-1:0] reloadReg;

  always_ff @(posedge SC_downTIMER_CLOCK_50) begin
    if (SC_downTIMER_RESET_InHigh) begin
      reloadReg <= '0;
    end else if (loadStrobe) begin
      reloadReg <= SC_downTIMER_loadValue_InBUS;
    end
  end
`endif

  assign loadStrobe = !SC_downTIMER_load_InLow;
  // Prescaler only advances in RUN when this edge is not a load or pause.
  assign preEnable  = (stateReg == RUN) && SC_downTIMER_pause_InLow && !loadStrobe;
  assign preClear   = loadStrobe || (stateNext == IDLE) || (stateNext == DONE);

  downtimer_prescaler #(
    .PRESCALE(DOWNTIMER_PRESCALE)
  ) prescaler (
    .SC_downTIMER_CLOCK_50    (SC_downTIMER_CLOCK_50),
    .SC_downTIMER_RESET_InHigh(SC_downTIMER_RESET_InHigh),
    .enable                   (preEnable),
    .clear                    (preClear),
    .tick                     (tick)
  );

  always_comb begin
    stateNext   = stateReg;
    countNext   = countReg;
    expiredNext = 1'b0;
    if (loadStrobe) begin
      countNext = SC_downTIMER_loadValue_InBUS;
      stateNext = (SC_downTIMER_loadValue_InBUS != '0) ? RUN : IDLE;
    end else begin
      case (stateReg)
        RUN: begin
          if (!SC_downTIMER_pause_InLow) begin
            stateNext = HOLD;
          end else if (tick) begin
            if (countReg == DW'(1)) begin
              expiredNext = 1'b1;
`ifdef FRAME_DOWNTIMER_AUTORELOAD_EN
              countNext   = reloadReg;
`else
              countNext   = '0;
              stateNext   = DONE;
`endif
            end else if (countReg != '0) begin
              countNext = countReg - DW'(1);
            end
          end
        end
        HOLD: begin
          if (SC_downTIMER_pause_InLow) begin
            stateNext = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SC_downTIMER_CLOCK_50) begin
    if (SC_downTIMER_RESET_InHigh) begin
      stateReg   <= IDLE;
      countReg   <= '0;
      expiredReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      countReg   <= countNext;
      expiredReg <= expiredNext;
    end
  end

  assign SC_downTIMER_data_OutBUS     = countReg;
  assign SC_downTIMER_expired_OutHigh = expiredReg;
  assign SC_downTIMER_running_OutHigh = (stateReg == RUN);

endmodule

// File: tb/tb_frame_downtimer.sv
// Directed self-checking bench for frame_downtimer with PRESCALE=4, DATAWIDTH=8.
// Honours FRAME_DOWNTIMER_AUTORELOAD_EN to select the expected expiry behaviour.
module tb_frame_downtimer;

`ifdef FRAME_DOWNTIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       loadN = 1'b1;
  logic [7:0] loadValue = '0;
  logic       pauseN = 1'b1;
  logic [7:0] data;
  logic       expired;
  logic       running;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    bit         rst;
    bit         loadN;
    logic [7:0] loadValue;
    bit         pauseN;
    logic [7:0] expData;
    bit         expExpired;
    bit         expRunning;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  frame_downtimer #(
    .DOWNTIMER_DATAWIDTH(8),
    .DOWNTIMER_PRESCALE (4)
  ) dut (
    .SC_downTIMER_CLOCK_50       (clk),
    .SC_downTIMER_RESET_InHigh   (rst),
    .SC_downTIMER_load_InLow     (loadN),
    .SC_downTIMER_loadValue_InBUS(loadValue),
    .SC_downTIMER_pause_InLow    (pauseN),
    .SC_downTIMER_data_OutBUS    (data),
    .SC_downTIMER_expired_OutHigh(expired),
    .SC_downTIMER_running_OutHigh(running)
  );

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, then compare all outputs 1 time unit later.
  task automatic step(input string name, input bit r, input bit ld, input logic [7:0] v,
                      input bit pz, input logic [7:0] eData, input bit eExp, input bit eRun);
    rst = r; loadN = ld; loadValue = v; pauseN = pz;
    @(posedge clk);
    #1;
    $display("%s: rst=%0b load_n=%0b val=%0d pause_n=%0b -> data=%0d expired=%0b running=%0b",
             name, r, ld, v, pz, data, expired, running);
    check({name, ".data"}, int'(data), int'(eData));
    check({name, ".expired"}, int'(expired), int'(eExp));
    check({name, ".running"}, int'(running), int'(eRun));
  endtask

  function automatic void add(bit r, bit ld, logic [7:0] v, bit pz,
                              logic [7:0] eData, bit eExp, bit eRun);
    vec_t t;
    t.rst = r; t.loadN = ld; t.loadValue = v; t.pauseN = pz;
    t.expData = eData; t.expExpired = eExp; t.expRunning = eRun;
    vecs.push_back(t);
  endfunction

  initial begin
    // Reset, load 3, count down through expiry, then pause in the end state and load 0.
    add(1, 1, 8'd0, 1, 8'd0, 0, 0);
    add(1, 1, 8'd0, 1, 8'd0, 0, 0);
    add(0, 0, 8'd3, 1, 8'd3, 0, 1);                 // edge 0
    for (int e = 1; e <= 11; e++) begin
      add(0, 1, 8'd0, 1, 8'(3 - e / 4), 0, 1);
    end
    add(0, 1, 8'd0, 1, AR ? 8'd3 : 8'd0, 1, AR);    // edge 12: expiry
    add(0, 1, 8'd0, 1, AR ? 8'd3 : 8'd0, 0, AR);
    add(0, 1, 8'd0, 0, AR ? 8'd3 : 8'd0, 0, 0);     // pause: DONE ignores, RUN holds
    add(0, 1, 8'd0, 0, AR ? 8'd3 : 8'd0, 0, 0);
    add(0, 0, 8'd0, 1, 8'd0, 0, 0);                 // load 0 -> IDLE
    for (int e = 0; e < 6; e++) begin
      add(0, 1, 8'd0, 1, 8'd0, 0, 0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].loadN, vecs[i].loadValue,
           vecs[i].pauseN, vecs[i].expData, vecs[i].expExpired, vecs[i].expRunning);
    end
    check("idle_state", int'(dut.stateReg), 0);

    // Pause for 5 cycles after edge 2, then the first decrement comes 2 cycles after release.
    step("pz_load", 0, 0, 8'd2, 1, 8'd2, 0, 1);
    step("pz_e1", 0, 1, 8'd0, 1, 8'd2, 0, 1);
    step("pz_e2", 0, 1, 8'd0, 1, 8'd2, 0, 1);
    for (int e = 3; e <= 7; e++) begin
      step($sformatf("pz_hold%0d", e), 0, 1, 8'd0, 0, 8'd2, 0, 0);
    end
    check("hold_state", int'(dut.stateReg), 2);
    step("pz_rel8", 0, 1, 8'd0, 1, 8'd2, 0, 1);
    step("pz_e9", 0, 1, 8'd0, 1, 8'd2, 0, 1);
    step("pz_e10", 0, 1, 8'd0, 1, 8'd1, 0, 1);
    step("pz_e11", 0, 1, 8'd0, 1, 8'd1, 0, 1);

    // Load 5 on the edge where count=1 would tick: load wins, no pulse.
    step("lt_load", 0, 0, 8'd2, 1, 8'd2, 0, 1);
    for (int e = 1; e <= 7; e++) begin
      step($sformatf("lt_e%0d", e), 0, 1, 8'd0, 1, e < 4 ? 8'd2 : 8'd1, 0, 1);
    end
    step("lt_reload", 0, 0, 8'd5, 1, 8'd5, 0, 1);
    step("lt_after", 0, 1, 8'd0, 1, 8'd5, 0, 1);

    // Reset mid-count abandons the count without an expiry pulse.
    step("rm_e2", 0, 1, 8'd0, 1, 8'd5, 0, 1);
    step("rm_reset", 1, 1, 8'd0, 1, 8'd0, 0, 0);
    for (int e = 0; e < 6; e++) begin
      step($sformatf("rm_post%0d", e), 0, 1, 8'd0, 1, 8'd0, 0, 0);
    end
    check("rm_state", int'(dut.stateReg), 0);

`ifdef FRAME_DOWNTIMER_AUTORELOAD_EN
    // Periodic expiry at edges 8, 16, 24 with reload to 2.
    step("ar_load", 0, 0, 8'd2, 1, 8'd2, 0, 1);
    for (int e = 1; e <= 25; e++) begin
      step($sformatf("ar_e%0d", e), 0, 1, 8'd0, 1, (e % 8) < 4 ? 8'd2 : 8'd1, (e % 8) == 0, 1);
    end
    // Reset at edge 10 of a fresh run suppresses all later pulses.
    step("ar2_load", 0, 0, 8'd2, 1, 8'd2, 0, 1);
    for (int e = 1; e <= 9; e++) begin
      step($sformatf("ar2_e%0d", e), 0, 1, 8'd0, 1, (e % 8) < 4 ? 8'd2 : 8'd1, e == 8, 1);
    end
    step("ar2_reset", 1, 1, 8'd0, 1, 8'd0, 0, 0);
    for (int e = 11; e <= 26; e++) begin
      step($sformatf("ar2_e%0d", e), 0, 1, 8'd0, 1, 8'd0, 0, 0);
    end
`else
    step("done_load", 0, 0, 8'd1, 1, 8'd1, 0, 1);
    for (int e = 1; e <= 3; e++) begin
      step($sformatf("done_e%0d", e), 0, 1, 8'd0, 1, 8'd1, 0, 1);
    end
    step("done_exp", 0, 1, 8'd0, 1, 8'd0, 1, 0);
    for (int e = 5; e <= 10; e++) begin
      step($sformatf("done_e%0d", e), 0, 1, 8'd0, 0, 8'd0, 0, 0);
    end
    check("done_state", int'(dut.stateReg), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/frame_downtimer.md
FRAME_DOWNTIMER -- requirements
Module: frame_downtimer

Interface
REQ-001 Parameter DOWNTIMER_DATAWIDTH, default 24, SHALL set the width of the count and load buses.
REQ-002 Parameter DOWNTIMER_PRESCALE, default 50000, SHALL set the number of clock cycles per count step; legal range 2..2^20.
REQ-003 SC_downTIMER_CLOCK_50  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 SC_downTIMER_RESET_InHigh  input  1  SHALL be a synchronous, active-high reset.
REQ-005 SC_downTIMER_load_InLow  input  1  SHALL be an active-low load strobe, sampled every edge.
REQ-006 SC_downTIMER_loadValue_InBUS  input  DATAWIDTH  SHALL carry the start value captured on load.
REQ-007 SC_downTIMER_pause_InLow  input  1  SHALL be an active-low pause request.
REQ-008 SC_downTIMER_data_OutBUS  output  DATAWIDTH  SHALL show the registered current count.
REQ-009 SC_downTIMER_expired_OutHigh  output  1  SHALL be a registered one-cycle expiry pulse.
REQ-010 SC_downTIMER_running_OutHigh  output  1  SHALL be high exactly while state is RUN.

Function
REQ-011 FSM states SHALL be IDLE, RUN, HOLD, DONE.
REQ-012 Prescaler counter SHALL count 0..PRESCALE-1 only in RUN, hold its value in HOLD, and clear to 0 on load, on entry to DONE/IDLE, and on reset.
REQ-013 A step tick SHALL occur on the edge where prescaler = PRESCALE-1 in RUN; count decrements by 1 on that edge.
REQ-014 Load low at edge k, any state: count = loadValue after edge k, prescaler = 0; next state RUN if loadValue != 0, else IDLE with no expiry pulse.
REQ-015 Load SHALL take priority over tick and pause in the same cycle.
REQ-016 RUN with pause low and no load SHALL go to HOLD; no tick occurs in that cycle.
REQ-017 HOLD with pause high SHALL return to RUN, resuming the prescaler from its held value.
REQ-018 Tick in RUN with count = 1: count becomes 0, state DONE, expired high for exactly the following cycle.
REQ-019 DONE SHALL hold count 0 and ignore pause until load or reset.
REQ-020 Count SHALL never wrap below 0; no decrement occurs in IDLE, HOLD or DONE.
REQ-021 Expired SHALL never stay high for two consecutive cycles.

Reset
REQ-022 Reset high at an edge SHALL force IDLE, count 0, prescaler 0, expired 0, running 0, and reload register 0, overriding load and pause.
REQ-023 Reset asserted mid-count SHALL abandon the count without an expiry pulse.

Configuration
REQ-024 Macro FRAME_DOWNTIMER_AUTORELOAD_EN SHALL be the only build option.
REQ-025 Defined: loadValue captured on load into a reload register; on expiry tick, count = reload value, state stays RUN, expired pulses once per period.
REQ-026 Undefined: no reload register exists; expiry SHALL go to DONE per REQ-018.

Structure
REQ-027 Shared package frame_downtimer_pkg SHALL hold the FSM state encoding (2 bits: IDLE=0, RUN=1, HOLD=2, DONE=3) and the default PRESCALE constant.
REQ-028 Sub-module downtimer_prescaler SHALL implement REQ-012/013 with inputs enable, clear and output tick.

Verification (bench uses PRESCALE=4, DATAWIDTH=8)
REQ-029 Reset high 2 cycles -> data=0, expired=0, running=0, state IDLE.
REQ-030 Load 3 at edge 0 -> data 3,2,1,0 after edges 0,4,8,12; expired high only in the cycle after edge 12; state DONE.
REQ-031 Load 2, pause low for 5 cycles after edge 2 -> count frozen at 2, running low; after release, the first decrement occurs 2 cycles later.
REQ-032 Load 5 and tick on the same edge with count=1 -> data=5, no expiry pulse.
REQ-033 Load 0 -> data=0, state IDLE, expired never asserted.
REQ-034 With FRAME_DOWNTIMER_AUTORELOAD_EN, load 2 -> expired pulses after edges 8, 16, 24; data reloads to 2 each time; reset at edge 10 -> data=0, no further pulses.
